// File: rtl/dwa_pkg.sv
// Shared constants and derivation helpers for the DWA encoder and its rotator.
package dwa_pkg;

   localparam int IN_W_DEF = 4;

   function automatic int n_elem_f(input int in_w);
      return 1 << in_w;
   endfunction

   function automatic int pw_f(input int in_w);
      return in_w;
   endfunction

   // Offset that maps the signed modulator code onto an unsigned element count.
   function automatic int mid_f(input int in_w);
      return 1 << (in_w - 1);
   endfunction

   localparam int MID_OFFSET = mid_f(IN_W_DEF);

endpackage

// File: rtl/therm_rotate.sv
// Combinational k-length thermometer mask, barrel-rotated to start at the pointer
// (forward) or to end just below it (backward), via a double-width shift.
module therm_rotate
   import dwa_pkg::*;
#(
   parameter int N  = n_elem_f(IN_W_DEF),
   parameter int PW = pw_f(IN_W_DEF)
) (
   input  logic [PW-1:0] k,
   input  logic [PW-1:0] ptr,
   input  logic          bwd,
   output logic [N-1:0]  mask_out
);

   logic [N-1:0]   mask;
   logic [PW-1:0]  sh;
   logic [2*N-1:0] dbl;

   // NOTE: every signal driven here is assigned on every path, so no latch is inferred.
   always_comb begin
      mask     = (N'(1) << k) - N'(1);
      sh       = bwd ? (ptr - k) : ptr;
      dbl      = {mask, mask} << sh;
      mask_out = dbl[2*N-1:N];
   end

endmodule

// File: rtl/dwa_encoder.sv
// Data-weighted-averaging encoder: signed modulator code -> rotating unit-element enables.
// Define DWA_BIDIR_EN to alternate rotation direction on every valid sample.
module dwa_encoder
   import dwa_pkg::*;
#(
   parameter  int IN_W   = IN_W_DEF,
   localparam int N_ELEM = n_elem_f(IN_W),
   localparam int PW     = pw_f(IN_W)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic signed [IN_W-1:0] din,
   input  logic                   din_valid,
   input  logic                   mute,
   output logic [N_ELEM-1:0]      elem_out,
   output logic                   dout_valid,
   output logic [PW-1:0]          ptr_out
);

   localparam logic [PW-1:0] MID_K = PW'(mid_f(IN_W));

   logic [PW-1:0]     ptr;
   logic [PW-1:0]     k;
   logic [PW-1:0]     ptr_nxt;
   logic [N_ELEM-1:0] mask;
   logic              dir_bwd;

   // Mute substitutes mid-scale but still advances the pointer.
   assign k = mute ? MID_K : ($unsigned(din) + MID_K);

`ifdef DWA_BIDIR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            dir_bwd <= 1'b0;
      else if (din_valid) dir_bwd <= ~dir_bwd;
   end
`else
   assign dir_bwd = 1'b0;
`endif

   assign ptr_nxt = dir_bwd ? (ptr - k) : (ptr + k);

   therm_rotate #(
      .N  (N_ELEM),
      .PW (PW)
   ) u_therm_rotate (
      .k        (k),
      .ptr      (ptr),
      .bwd      (dir_bwd),
      .mask_out (mask)
   );

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         elem_out   <= '0;
         ptr        <= '0;
         dout_valid <= 1'b0;
      end else begin
         dout_valid <= din_valid;
         if (din_valid) begin
            elem_out <= mask;
            ptr      <= ptr_nxt;
         end
      end
   end

   assign ptr_out = ptr;

endmodule

// File: tb/tb_dwa_encoder.sv
// Directed self-checking bench for dwa_encoder (IN_W=4, N_ELEM=16).
module tb_dwa_encoder;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic signed [3:0] din = '0;
   logic              din_valid = 1'b0;
   logic              mute = 1'b0;
   logic [15:0]       elem_out;
   logic              dout_valid;
   logic [3:0]        ptr_out;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dwa_encoder #(.IN_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_valid  (din_valid),
      .mute       (mute),
      .elem_out   (elem_out),
      .dout_valid (dout_valid),
      .ptr_out    (ptr_out)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [15:0] e_elem,
                          input logic [3:0] e_ptr, input logic e_dv);
      check({tag, ".elem"}, 32'(elem_out), 32'(e_elem));
      check({tag, ".ptr"},  32'(ptr_out),  32'(e_ptr));
      check({tag, ".dv"},   32'(dout_valid), 32'(e_dv));
   endtask

   // Drive one cycle of input, then sample 1 ns after the capturing edge.
   task automatic step(input logic signed [3:0] d, input logic m, input logic v);
      din = d; mute = m; din_valid = v;
      @(posedge clk);
      #1;
      din = '0; mute = 1'b0; din_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #12;
      chk_out("reset", 16'h0000, 4'd0, 1'b0);
      rst = 1'b0;

      // Mid-scale twice: forward run then the complementary half.
      step(4'sd0, 1'b0, 1'b1);
      chk_out("zero1", 16'h00FF, 4'd8, 1'b1);
      step(4'sd0, 1'b0, 1'b1);
`ifdef DWA_BIDIR_EN
      chk_out("zero2", 16'h00FF, 4'd0, 1'b1);
`else
      chk_out("zero2", 16'hFF00, 4'd0, 1'b1);
`endif
      step(4'sd0, 1'b0, 1'b0);
      chk_out("zero_idle", 16'h00FF ^ (`ifdef DWA_BIDIR_EN 16'h0000 `else 16'hFFFF `endif), 4'd0, 1'b0);

      // Full-scale then k=1.
      do_reset();
      step(4'sd7, 1'b0, 1'b1);
      chk_out("max", 16'h7FFF, 4'd15, 1'b1);
      step(-4'sd7, 1'b0, 1'b1);
`ifdef DWA_BIDIR_EN
      chk_out("k1", 16'h4000, 4'd14, 1'b1);
`else
      chk_out("k1", 16'h8000, 4'd0, 1'b1);
`endif

      // Wrap-around then k=0.
      do_reset();
      step(4'sd4, 1'b0, 1'b1);
      chk_out("to12", 16'h0FFF, 4'd12, 1'b1);
      step(-4'sd2, 1'b0, 1'b1);
`ifdef DWA_BIDIR_EN
      chk_out("wrap", 16'h0FC0, 4'd6, 1'b1);
      step(-4'sd8, 1'b0, 1'b1);
      chk_out("k0", 16'h0000, 4'd6, 1'b1);
`else
      chk_out("wrap", 16'hF003, 4'd2, 1'b1);
      step(-4'sd8, 1'b0, 1'b1);
      chk_out("k0", 16'h0000, 4'd2, 1'b1);
`endif

      // Hold through idle cycles; din changes must be ignored.
      do_reset();
      step(4'sd0, 1'b0, 1'b1);
      chk_out("hold_load", 16'h00FF, 4'd8, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(4'sd5, 1'b0, 1'b0);
         chk_out($sformatf("hold%0d", i), 16'h00FF, 4'd8, 1'b0);
      end

      // Mute overrides din and still rotates; mute without valid does nothing.
      do_reset();
      step(-4'sd5, 1'b0, 1'b1);
      chk_out("to3", 16'h0007, 4'd3, 1'b1);
      step(4'sd7, 1'b1, 1'b1);
`ifdef DWA_BIDIR_EN
      chk_out("mute", 16'hF807, 4'd11, 1'b1);
      step(4'sd7, 1'b1, 1'b0);
      chk_out("mute_nv", 16'hF807, 4'd11, 1'b0);
`else
      chk_out("mute", 16'h07F8, 4'd11, 1'b1);
      step(4'sd7, 1'b1, 1'b0);
      chk_out("mute_nv", 16'h07F8, 4'd11, 1'b0);
`endif

      // Asynchronous reset between edges, then restart from ptr 0.
      step(4'sd3, 1'b0, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk_out("async_rst", 16'h0000, 4'd0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      step(4'sd0, 1'b0, 1'b1);
      chk_out("post_rst1", 16'h00FF, 4'd8, 1'b1);
      step(4'sd0, 1'b0, 1'b1);
`ifdef DWA_BIDIR_EN
      chk_out("post_rst2", 16'h00FF, 4'd0, 1'b1);
`else
      chk_out("post_rst2", 16'hFF00, 4'd0, 1'b1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
